// File: rtl/ad9253_cfg_seq.sv
// -----------------------------------------------------------------------------
// ad9253_cfg_seq
//
// Configuration sequencer in front of the AD9253 SPI interface. After reset
// (or cfg_start) it waits PWRUP_WAIT cycles, writes the fixed init table
// (soft reset, channel select, output config, transfer), reads the chip ID
// and reports the result. In IDLE it then serves single-register host
// reads/writes.
//
// Optional build macro:
//   AD9253_CFG_VERIFY_EN - read back every table write except the soft reset
//                          and the transfer write, and flag mismatches
//                          (err_code = 2).
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   cfg_start         pulse, restarts the init sequence (IDLE/ERROR only)
//   wr_data_en/wr_data   one-cycle write request + {3'b000, addr, data}
//   rd_add_en/rd_add     one-cycle read request + address
//   spi_busy          SPI interface busy
//   rd_data_en/rd_data   read data strobe + data from the SPI interface
//   host_req/rw/addr/wdata  host access request (level, held until ack)
//   host_ack          one-cycle completion pulse
//   host_rdata        last host read data
//   cfg_done          init passed
//   cfg_err/err_code  sticky error: 1 = chip ID, 2 = verify, 3 = timeout
// -----------------------------------------------------------------------------
module ad9253_cfg_seq #(
  parameter int unsigned PWRUP_WAIT = 1000,
  parameter int unsigned SRST_WAIT  = 2000,
  parameter int unsigned TIMEOUT    = 4095,
  parameter logic [7:0]  CHIP_ID    = 8'h82
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  output logic        wr_data_en,
  output logic [23:0] wr_data,
  output logic        rd_add_en,
  output logic [12:0] rd_add,
  input  logic        spi_busy,
  input  logic        rd_data_en,
  input  logic [7:0]  rd_data,
  input  logic        host_req,
  input  logic        host_rw,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [1:0]  err_code
);

  typedef enum logic [3:0] {
    S_PWRUP,
    S_ISSUE,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_SRST_DLY,
    S_IDLE,
    S_HOST_ISSUE,
    S_HOST_RISE,
    S_HOST_FALL,
    S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ID      = 2'd1,
    ERR_VERIFY  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  // One entry of the init program. Reads carry the value they must return.
  typedef struct packed {
    logic        rd;
    logic [12:0] addr;
    logic [7:0]  data;
  } step_t;

`ifdef AD9253_CFG_VERIFY_EN
  localparam int unsigned N_STEPS = 9;
`else
  localparam int unsigned N_STEPS = 6;
`endif
  localparam logic [3:0]  LAST_STEP  = 4'(N_STEPS - 1);
  localparam logic [15:0] PWRUP_LAST = 16'(PWRUP_WAIT - 1);
  localparam logic [15:0] SRST_LAST  = 16'(SRST_WAIT - 1);
  localparam logic [11:0] WD_LIMIT   = 12'(TIMEOUT);

  // Init program; the last step is always the chip-ID read.
  function automatic step_t step_at(input logic [3:0] idx);
    step_t s;
    // NOTE: give every output of a combinational function/block a default
    // first, so no path leaves it unassigned and no latch is inferred.
    s = '{rd: 1'b1, addr: 13'h001, data: CHIP_ID};
    case (idx)
`ifdef AD9253_CFG_VERIFY_EN
      4'd0: s = '{rd: 1'b0, addr: 13'h000, data: 8'h3C};
      4'd1: s = '{rd: 1'b0, addr: 13'h005, data: 8'h3F};
      4'd2: s = '{rd: 1'b1, addr: 13'h005, data: 8'h3F};
      4'd3: s = '{rd: 1'b0, addr: 13'h014, data: 8'h01};
      4'd4: s = '{rd: 1'b1, addr: 13'h014, data: 8'h01};
      4'd5: s = '{rd: 1'b0, addr: 13'h021, data: 8'h30};
      4'd6: s = '{rd: 1'b1, addr: 13'h021, data: 8'h30};
      4'd7: s = '{rd: 1'b0, addr: 13'h0FF, data: 8'h01};
`else
      4'd0: s = '{rd: 1'b0, addr: 13'h000, data: 8'h3C};
      4'd1: s = '{rd: 1'b0, addr: 13'h005, data: 8'h3F};
      4'd2: s = '{rd: 1'b0, addr: 13'h014, data: 8'h01};
      4'd3: s = '{rd: 1'b0, addr: 13'h021, data: 8'h30};
      4'd4: s = '{rd: 1'b0, addr: 13'h0FF, data: 8'h01};
`endif
      default: ;
    endcase
    return s;
  endfunction

  state_t      state;
  logic [3:0]  step;
  logic [15:0] dly_cnt;
  logic [11:0] wd_cnt;
  logic        h_rw;
  logic [12:0] h_addr;
  logic [7:0]  h_wdata;
  step_t       cur;

  assign cur = step_at(step);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_PWRUP;
      step       <= '0;
      dly_cnt    <= '0;
      wd_cnt     <= '0;
      h_rw       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      wr_data_en <= 1'b0;
      wr_data    <= '0;
      rd_add_en  <= 1'b0;
      rd_add     <= '0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      // Request and ack strobes are single-cycle by default.
      wr_data_en <= 1'b0;
      rd_add_en  <= 1'b0;
      host_ack   <= 1'b0;

      case (state)
        S_PWRUP: begin
          if (dly_cnt == PWRUP_LAST) begin
            dly_cnt <= '0;
            step    <= '0;
            state   <= S_ISSUE;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end

        S_ISSUE: begin
          if (!spi_busy) begin
            if (cur.rd) begin
              rd_add_en <= 1'b1;
              rd_add    <= cur.addr;
            end else begin
              wr_data_en <= 1'b1;
              wr_data    <= {3'b000, cur.addr, cur.data};
            end
            wd_cnt <= '0;
            state  <= S_WAIT_RISE;
          end
        end

        // The watchdog spans both wait states: it bounds the whole transaction.
        S_WAIT_RISE: begin
          if (wd_cnt == WD_LIMIT) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERROR;
          end else begin
            wd_cnt <= wd_cnt + 12'd1;
            if (spi_busy) state <= S_WAIT_FALL;
          end
        end

        S_WAIT_FALL: begin
          if (cur.rd ? rd_data_en : !spi_busy) begin
            if (cur.rd && step == LAST_STEP) begin
              if (rd_data == CHIP_ID) begin
                cfg_done <= 1'b1;
                state    <= S_IDLE;
              end else begin
                cfg_err  <= 1'b1;
                err_code <= ERR_ID;
                state    <= S_ERROR;
              end
            end else if (cur.rd && rd_data != cur.data) begin
              cfg_err  <= 1'b1;
              err_code <= ERR_VERIFY;
              state    <= S_ERROR;
            end else if (!cur.rd && cur.addr == 13'h000) begin
              // Soft reset: the chip needs a quiet period before the next access.
              dly_cnt <= '0;
              state   <= S_SRST_DLY;
            end else begin
              step  <= step + 4'd1;
              state <= S_ISSUE;
            end
          end else if (wd_cnt == WD_LIMIT) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERROR;
          end else begin
            wd_cnt <= wd_cnt + 12'd1;
          end
        end

        S_SRST_DLY: begin
          if (dly_cnt == SRST_LAST) begin
            dly_cnt <= '0;
            step    <= step + 4'd1;
            state   <= S_ISSUE;
          end else begin
            dly_cnt <= dly_cnt + 16'd1;
          end
        end

        S_IDLE: begin
          // cfg_start has priority; a simultaneous host_req simply stays pending.
          if (cfg_start) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_code <= ERR_NONE;
            dly_cnt  <= '0;
            step     <= '0;
            state    <= S_PWRUP;
          end else if (host_req) begin
            h_rw    <= host_rw;
            h_addr  <= host_addr;
            h_wdata <= host_wdata;
            state   <= S_HOST_ISSUE;
          end
        end

        S_HOST_ISSUE: begin
          if (!spi_busy) begin
            if (h_rw) begin
              rd_add_en <= 1'b1;
              rd_add    <= h_addr;
            end else begin
              wr_data_en <= 1'b1;
              wr_data    <= {3'b000, h_addr, h_wdata};
            end
            wd_cnt <= '0;
            state  <= S_HOST_RISE;
          end
        end

        S_HOST_RISE: begin
          if (wd_cnt == WD_LIMIT) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERROR;
          end else begin
            wd_cnt <= wd_cnt + 12'd1;
            if (spi_busy) state <= S_HOST_FALL;
          end
        end

        S_HOST_FALL: begin
          if (h_rw ? rd_data_en : !spi_busy) begin
            host_ack <= 1'b1;
            if (h_rw) host_rdata <= rd_data;
            state <= S_IDLE;
          end else if (wd_cnt == WD_LIMIT) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b1;
            err_code <= ERR_TIMEOUT;
            state    <= S_ERROR;
          end else begin
            wd_cnt <= wd_cnt + 12'd1;
          end
        end

        S_ERROR: begin
          wr_data <= '0;
          rd_add  <= '0;
          if (cfg_start) begin
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            err_code <= ERR_NONE;
            dly_cnt  <= '0;
            step     <= '0;
            state    <= S_PWRUP;
          end
        end

        default: begin
          dly_cnt <= '0;
          state   <= S_PWRUP;
        end
      endcase
    end
  end

endmodule
